blt_ctrl: RTL and testbench

BLT_CTRL -- requirements
Module: blt_ctrl

---
 rtl/blt_ctrl_pkg.sv | 36 +++
 rtl/blt_array.sv | 92 +++++++++
 rtl/blt_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_blt_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blt_ctrl_pkg.sv
// Shared defines and types for the branch lookup table controller.
// Optional feature macro: BLT_STATS_EN builds the lookup/hit/mispredict counters.
`ifndef BLT_CTRL_DEFS
`define BLT_CTRL_DEFS
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`define JMP_OP             6'b000010
`define BLT_CNT_WEAK_TAKEN 2'd2
`define BLT_CNT_MAX        2'd3
`define BLT_ST_IDLE        1'b0
`define BLT_ST_CLEAR       1'b1
`endif

package blt_ctrl_pkg;

    localparam logic [1:0] BLT_CNT_WEAK_TAKEN = `BLT_CNT_WEAK_TAKEN;
    localparam logic [1:0] BLT_CNT_MAX        = `BLT_CNT_MAX;

    typedef enum logic {
        BLT_IDLE  = `BLT_ST_IDLE,
        BLT_CLEAR = `BLT_ST_CLEAR
    } blt_state_e;

    // Two-bit saturating step: up moves towards BLT_CNT_MAX, down towards zero.
    function automatic logic [1:0] blt_sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cnt == BLT_CNT_MAX) ? cnt : cnt + 2'd1;
        end else begin
            res = (cnt == 2'd0) ? cnt : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/blt_array.sv
// Branch lookup table storage: two combinational tag-search ports, one write
// port and a single-entry invalidate port.
module blt_array
    import blt_ctrl_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int AW      = 32,
    localparam int IW     = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rd_pc_i,
    output logic          rd_match_o,
    output logic          rd_taken_o,
    output logic [AW-1:0] rd_target_o,
    input  logic [AW-1:0] up_pc_i,
    output logic          up_match_o,
    output logic [IW-1:0] up_idx_o,
    output logic [1:0]    up_cnt_o,
    output logic [AW-1:0] up_target_o,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [AW-1:0] wr_tag_i,
    input  logic [AW-1:0] wr_target_i,
    input  logic [1:0]    wr_cnt_i,
    input  logic          inv_en_i,
    input  logic [IW-1:0] inv_idx_i
);

    logic [ENTRIES-1:0] valid_q;
    logic [AW-1:0]      tag_q    [ENTRIES];
    logic [AW-1:0]      target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    // Fetch-side search; allocation guarantees at most one entry per tag.
    always_comb begin
        rd_match_o  = 1'b0;
        rd_taken_o  = 1'b0;
        rd_target_o = {AW{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == rd_pc_i)) begin
                rd_match_o  = 1'b1;
                rd_taken_o  = cnt_q[i][1];
                rd_target_o = target_q[i];
            end else begin
                rd_match_o = rd_match_o;
            end
        end
    end

    // Update-side search against the live table contents.
    always_comb begin
        up_match_o  = 1'b0;
        up_idx_o    = {IW{1'b0}};
        up_cnt_o    = 2'd0;
        up_target_o = {AW{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == up_pc_i)) begin
                up_match_o  = 1'b1;
                up_idx_o    = IW'(i);
                up_cnt_o    = cnt_q[i];
                up_target_o = target_q[i];
            end else begin
                up_match_o = up_match_o;
            end
        end
    end

    // Entry storage; invalidation takes priority over a write to the same slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= {AW{1'b0}};
                target_q[i] <= {AW{1'b0}};
                cnt_q[i]    <= 2'd0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (inv_en_i && (inv_idx_i == IW'(i))) begin
                    valid_q[i] <= 1'b0;
                end else if (wr_en_i && (wr_idx_i == IW'(i))) begin
                    valid_q[i]  <= 1'b1;
                    tag_q[i]    <= wr_tag_i;
                    target_q[i] <= wr_target_i;
                    cnt_q[i]    <= wr_cnt_i;
                end
            end
        end
    end

endmodule

// File: rtl/blt_ctrl.sv
// Branch lookup table controller: two-stage update pipeline, round-robin
// allocation, invalidation sweep FSM and optional event counters (BLT_STATS_EN).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
module blt_ctrl
    import blt_ctrl_pkg::*;
#(
    parameter int BLT_ENTRIES = 8,
    parameter int ADDR_WIDTH  = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict,
    input  logic [ADDR_WIDTH-1:0] rd_pc,
    output logic                  rd_hit,
    output logic [ADDR_WIDTH-1:0] rd_target,
    input  logic                  inv_req,
    output logic                  inv_busy,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_mispredicts
);

    localparam int            IW       = $clog2(BLT_ENTRIES);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BLT_ENTRIES - 1);

    blt_state_e              state_q, state_d;
    logic [IW-1:0]           sweep_q, sweep_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic                    updv_q, updv_d;
    logic [ADDR_WIDTH-1:0]   upd_pc_q, upd_pc_d;
    logic [ADDR_WIDTH-1:0]   upd_tgt_q, upd_tgt_d;
    logic                    upd_tk_q, upd_tk_d;

    logic                    rd_match_s, rd_taken_s;
    logic [ADDR_WIDTH-1:0]   rd_tgt_s;
    logic                    up_match_s;
    logic [IW-1:0]           up_idx_s;
    logic [1:0]              up_cnt_s;
    logic [ADDR_WIDTH-1:0]   up_tgt_s;
    logic                    wr_en_s;
    logic [IW-1:0]           wr_idx_s;
    logic [ADDR_WIDTH-1:0]   wr_tgt_s;
    logic [1:0]              wr_cnt_s;
    logic                    inv_en_s;

    blt_array #(
        .ENTRIES (BLT_ENTRIES),
        .AW      (ADDR_WIDTH)
    ) u_array (
        .clk         (clk),
        .reset       (reset),
        .rd_pc_i     (rd_pc),
        .rd_match_o  (rd_match_s),
        .rd_taken_o  (rd_taken_s),
        .rd_target_o (rd_tgt_s),
        .up_pc_i     (upd_pc_q),
        .up_match_o  (up_match_s),
        .up_idx_o    (up_idx_s),
        .up_cnt_o    (up_cnt_s),
        .up_target_o (up_tgt_s),
        .wr_en_i     (wr_en_s),
        .wr_idx_i    (wr_idx_s),
        .wr_tag_i    (upd_pc_q),
        .wr_target_i (wr_tgt_s),
        .wr_cnt_i    (wr_cnt_s),
        .inv_en_i    (inv_en_s),
        .inv_idx_i   (sweep_q)
    );

    // Capture stage: updates arriving during a sweep are dropped here.
    always_comb begin
        updv_d    = upd_valid && (state_q == BLT_IDLE);
        upd_pc_d  = upd_pc_q;
        upd_tgt_d = upd_tgt_q;
        upd_tk_d  = upd_tk_q;
        if (upd_valid) begin
            upd_pc_d  = upd_pc;
            upd_tgt_d = upd_target;
            upd_tk_d  = upd_taken;
        end else begin
            upd_tk_d = upd_tk_q;
        end
    end

    // Apply stage and sweep FSM; an apply still completes in the cycle inv_req arrives.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        rr_ptr_d = rr_ptr_q;
        wr_en_s  = 1'b0;
        wr_idx_s = rr_ptr_q;
        wr_tgt_s = upd_tgt_q;
        wr_cnt_s = BLT_CNT_WEAK_TAKEN;
        inv_en_s = 1'b0;
        case (state_q)
            BLT_IDLE: begin
                if (updv_q && up_match_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = up_idx_s;
                    wr_cnt_s = blt_sat_step(up_cnt_s, upd_tk_q);
                    wr_tgt_s = upd_tk_q ? upd_tgt_q : up_tgt_s;
                end else if (updv_q && upd_tk_q) begin
                    wr_en_s  = 1'b1;
                    rr_ptr_d = rr_ptr_q + IDX_ONE;
                end else begin
                    wr_en_s = 1'b0;
                end
                if (inv_req) begin
                    state_d = BLT_CLEAR;
                    sweep_d = {IW{1'b0}};
                end else begin
                    state_d = BLT_IDLE;
                end
            end
            BLT_CLEAR: begin
                inv_en_s = 1'b1;
                if (sweep_q == IDX_LAST) begin
                    state_d  = BLT_IDLE;
                    sweep_d  = {IW{1'b0}};
                    rr_ptr_d = {IW{1'b0}};
                end else begin
                    sweep_d = sweep_q + IDX_ONE;
                end
            end
            default: begin
                state_d = BLT_IDLE;
            end
        endcase
    end

    // Control and update-pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BLT_IDLE;
            sweep_q   <= {IW{1'b0}};
            rr_ptr_q  <= {IW{1'b0}};
            updv_q    <= 1'b0;
            upd_pc_q  <= {ADDR_WIDTH{1'b0}};
            upd_tgt_q <= {ADDR_WIDTH{1'b0}};
            upd_tk_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            rr_ptr_q  <= rr_ptr_d;
            updv_q    <= updv_d;
            upd_pc_q  <= upd_pc_d;
            upd_tgt_q <= upd_tgt_d;
            upd_tk_q  <= upd_tk_d;
        end
    end

    // Lookup result; forced to miss for the whole sweep.
    always_comb begin
        rd_hit    = 1'b0;
        rd_target = {ADDR_WIDTH{1'b0}};
        if ((state_q == BLT_IDLE) && rd_match_s && rd_taken_s) begin
            rd_hit    = 1'b1;
            rd_target = rd_tgt_s;
        end else begin
            rd_hit = 1'b0;
        end
    end

    assign inv_busy = (state_q == BLT_CLEAR);

`ifdef BLT_STATS_EN
    logic [31:0] lookups_q, hits_q, misp_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lookups_q <= 32'd0;
            hits_q    <= 32'd0;
            misp_q    <= 32'd0;
        end else begin
            if (state_q == BLT_IDLE) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (rd_hit) begin
                hits_q <= hits_q + 32'd1;
            end
            if (upd_valid && upd_mispredict) begin
                misp_q <= misp_q + 32'd1;
            end
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = misp_q;
`else
    logic unused_misp_s;
    assign unused_misp_s    = upd_mispredict;
    assign stat_lookups     = 32'd0;
    assign stat_hits        = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_blt_ctrl.sv
// Self-checking bench for blt_ctrl: directed scenarios plus randomized traffic
// against a table-level reference model.
module tb_blt_ctrl;

    localparam int N  = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_taken;
    logic          upd_mispredict;
    logic [AW-1:0] rd_pc;
    logic          rd_hit;
    logic [AW-1:0] rd_target;
    logic          inv_req;
    logic          inv_busy;
    logic [31:0]   stat_lookups, stat_hits, stat_mispredicts;

    always #5 clk = ~clk;

    blt_ctrl #(.BLT_ENTRIES(N), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .rd_pc            (rd_pc),
        .rd_hit           (rd_hit),
        .rd_target        (rd_target),
        .inv_req          (inv_req),
        .inv_busy         (inv_busy),
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the table as plain arrays plus the pending update.
    bit            mv [N];
    logic [AW-1:0] mt [N];
    logic [AW-1:0] mg [N];
    int            mc [N];
    int            mrr, msweep;
    bit            mbusy;
    bit            pv, ptk;
    logic [AW-1:0] ppc, ptgt;
    logic [31:0]   m_look, m_hits, m_misp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mlook(input logic [AW-1:0] pc, output bit h, output logic [AW-1:0] t);
        h = 1'b0;
        t = '0;
        if (!mbusy) begin
            for (int i = 0; i < N; i++) begin
                if (mv[i] && mt[i] == pc && mc[i] >= 2) begin
                    h = 1'b1;
                    t = mg[i];
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            mc[i] = 0;
        end
        mrr = 0; msweep = 0; mbusy = 1'b0; pv = 1'b0;
        m_look = 32'd0; m_hits = 32'd0; m_misp = 32'd0;
    endtask

    task automatic model_edge();
        bit h;
        logic [AW-1:0] t;
        int hi;
        mlook(rd_pc, h, t);
        if (!mbusy) m_look = m_look + 32'd1;
        if (h) m_hits = m_hits + 32'd1;
        if (upd_valid && upd_mispredict) m_misp = m_misp + 32'd1;
        if (mbusy) begin
            mv[msweep] = 1'b0;
            pv = 1'b0;
            if (msweep == N - 1) begin
                mbusy = 1'b0;
                mrr = 0;
            end else begin
                msweep++;
            end
        end else begin
            if (pv) begin
                hi = -1;
                for (int i = 0; i < N; i++) if (mv[i] && mt[i] == ppc) hi = i;
                if (hi >= 0) begin
                    if (ptk) begin
                        mc[hi] = (mc[hi] < 3) ? mc[hi] + 1 : 3;
                        mg[hi] = ptgt;
                    end else begin
                        mc[hi] = (mc[hi] > 0) ? mc[hi] - 1 : 0;
                    end
                end else if (ptk) begin
                    mv[mrr] = 1'b1; mt[mrr] = ppc; mg[mrr] = ptgt; mc[mrr] = 2;
                    mrr = (mrr + 1) % N;
                end
            end
            if (inv_req) begin
                mbusy = 1'b1;
                msweep = 0;
            end
            pv = upd_valid; ppc = upd_pc; ptgt = upd_target; ptk = upd_taken;
        end
    endtask

    task automatic check_outputs();
        bit h;
        logic [AW-1:0] t;
        mlook(rd_pc, h, t);
        chk("rd_hit", 64'(rd_hit), 64'(h));
        chk("rd_target", 64'(rd_target), h ? 64'(t) : 64'd0);
        chk("inv_busy", 64'(inv_busy), 64'(mbusy));
`ifdef BLT_STATS_EN
        chk("stat_lookups", 64'(stat_lookups), 64'(m_look));
        chk("stat_hits", 64'(stat_hits), 64'(m_hits));
        chk("stat_misp", 64'(stat_mispredicts), 64'(m_misp));
`else
        chk("stat_lookups", 64'(stat_lookups), 64'd0);
        chk("stat_hits", 64'(stat_hits), 64'd0);
        chk("stat_misp", 64'(stat_mispredicts), 64'd0);
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; inv_req = 1'b0;
        #1;
        model_reset();
        chk("rst_hit", 64'(rd_hit), 64'd0);
        chk("rst_target", 64'(rd_target), 64'd0);
        chk("rst_busy", 64'(inv_busy), 64'd0);
        chk("rst_stats", 64'(stat_lookups | stat_hits | stat_mispredicts), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic upd(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input bit tk, input bit mis);
        upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_mispredict = mis;
        tick();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    initial begin
        int busy_cnt, dup, idx;
        reset = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        upd_mispredict = 1'b0; rd_pc = '0; inv_req = 1'b0;

        // Taken allocation visible two edges later with weak-taken counter.
        do_reset();
        upd(32'h10, 32'h40, 1'b1, 1'b0);
        tick();
        rd_pc = 32'h10;
        #1;
        chk("r37_hit", 64'(rd_hit), 64'd1);
        chk("r37_target", 64'(rd_target), 64'h40);
        chk("r37_cnt", 64'(dut.u_array.cnt_q[0]), 64'd2);

        // Not-taken decay floors at zero, entry stays valid.
        upd(32'h10, 32'h40, 1'b0, 1'b0);
        tick();
        chk("r38_miss1", 64'(rd_hit), 64'd0);
        upd(32'h10, 32'h40, 1'b0, 1'b0);
        upd(32'h10, 32'h40, 1'b0, 1'b0);
        tick();
        chk("r38_floor", 64'(dut.u_array.cnt_q[0]), 64'd0);
        chk("r38_valid", 64'(dut.u_array.valid_q[0]), 64'd1);
        upd(32'h10, 32'h44, 1'b1, 1'b0);
        tick();
        chk("r38_cnt1", 64'(dut.u_array.cnt_q[0]), 64'd1);
        chk("r38_hit", 64'(rd_hit), 64'd0);

        // Round-robin eviction after nine distinct allocations.
        do_reset();
        for (int k = 0; k < 9; k++) upd(32'h100 + 32'(k), 32'h200 + 32'(k), 1'b1, 1'b0);
        tick();
        chk("r39_tag0", 64'(dut.u_array.tag_q[0]), 64'h108);
        chk("r39_rr", 64'(dut.rr_ptr_q), 64'd1);
        rd_pc = 32'h100;
        #1;
        chk("r39_evicted", 64'(rd_hit), 64'd0);
        rd_pc = 32'h101;
        #1;
        chk("r39_kept", 64'(rd_target), 64'h201);

        // Back-to-back updates to one PC share a single entry.
        upd(32'h20, 32'h80, 1'b1, 1'b0);
        upd(32'h20, 32'h84, 1'b1, 1'b0);
        tick();
        dup = 0; idx = 0;
        for (int i = 0; i < N; i++) begin
            if (dut.u_array.valid_q[i] && dut.u_array.tag_q[i] == 32'h20) begin
                dup++;
                idx = i;
            end
        end
        chk("r40_entries", 64'(dup), 64'd1);
        chk("r40_cnt", 64'(dut.u_array.cnt_q[idx]), 64'd3);

        // Full sweep with five valid entries.
        do_reset();
        for (int k = 0; k < 5; k++) upd(32'h300 + 32'(k * 4), 32'h900 + 32'(k), 1'b1, 1'b0);
        tick();
        rd_pc = 32'h300;
        inv_req = 1'b1;
        tick();
        inv_req = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (inv_busy === 1'b1) busy_cnt++;
            tick();
        end
        chk("r41_busy_cycles", 64'(busy_cnt), 64'd8);
        chk("r41_valid", 64'(dut.u_array.valid_q), 64'd0);
        chk("r41_rr", 64'(dut.rr_ptr_q), 64'd0);

        // Apply coinciding with inv_req completes, then gets swept.
        upd(32'h400, 32'h500, 1'b1, 1'b0);
        inv_req = 1'b1;
        tick();
        inv_req = 1'b0;
        chk("r28_applied", 64'(dut.u_array.valid_q[0]), 64'd1);
        for (int k = 0; k < 9; k++) tick();
        chk("r28_swept", 64'(dut.u_array.valid_q), 64'd0);

        // Reset during sweep cycle 3.
        for (int k = 0; k < 3; k++) upd(32'h600 + 32'(k * 4), 32'h700, 1'b1, 1'b0);
        tick();
        inv_req = 1'b1;
        tick();
        inv_req = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("r41_busy_pre", 64'(inv_busy), 64'd1);
        do_reset();
        chk("r41_rst_valid", 64'(dut.u_array.valid_q), 64'd0);

        // Mispredict counting (zero when counters are not built).
        do_reset();
        upd(32'h10, 32'h20, 1'b1, 1'b1);
        upd(32'h14, 32'h20, 1'b0, 1'b0);
        upd(32'h18, 32'h20, 1'b1, 1'b1);
        upd(32'h1c, 32'h20, 1'b0, 1'b0);
`ifdef BLT_STATS_EN
        chk("r42_misp", 64'(stat_mispredicts), 64'd2);
`else
        chk("r42_misp", 64'(stat_mispredicts), 64'd0);
`endif

        // Randomized traffic over a small PC set to force matches and evictions.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            upd_valid      = ($urandom_range(0, 1) == 1);
            upd_pc         = 32'h40 + 32'($urandom_range(0, 11)) * 32'd4;
            upd_target     = 32'($urandom);
            upd_taken      = ($urandom_range(0, 9) < 7);
            upd_mispredict = ($urandom_range(0, 3) == 0);
            rd_pc          = 32'h40 + 32'($urandom_range(0, 11)) * 32'd4;
            inv_req        = ($urandom_range(0, 39) == 0);
            tick();
        end
        upd_valid = 1'b0; inv_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("rand_valid", 64'(dut.u_array.valid_q[i]), 64'(mv[i]));
            if (mv[i]) begin
                chk("rand_tag", 64'(dut.u_array.tag_q[i]), 64'(mt[i]));
                chk("rand_cnt", 64'(dut.u_array.cnt_q[i]), 64'(mc[i]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
